mc_controller: RTL and testbench

Multicycle sequencer for the RV32I core. It replaces the single-cycle main decoder when the datapath is rebuilt around one shared instruction/data memory plus the non-architectural registers IR, OldPC, A, WriteData, Data and ALUOut. A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback, and stalls on a memory-ready handshake. A combinational ALU decoder drives ALUControl.

---
 rtl/mc_pkg.sv | 63 ++++++
 rtl/alu_dec.sv | 39 +++
 rtl/mc_controller.sv | 149 ++++++++++++++
 tb/tb_mc_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// mc_pkg : shared encodings for the multicycle RV32I controller
// Rev 1.0
// ============================================================================
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // alu_op: fixed add, fixed sub, or decode from funct3/funct7
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/alu_dec.sv
`default_nettype none
// ============================================================================
// alu_dec : combinational ALU operation decoder
// Rev 1.0
// ============================================================================
module alu_dec
    import mc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    input  logic [1:0] alu_op,
    output logic [3:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // addi has no sub form, so bit 30 only matters for R-type
                    3'b000:  ALUControl = (funct7b5 && is_rtype) ? ALU_SUB : ALU_ADD;
                    3'b001:  ALUControl = ALU_SLL;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b011:  ALUControl = ALU_SLTU;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  ALUControl = ALU_OR;
                    default: ALUControl = ALU_AND;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// mc_controller : multicycle RV32I Moore sequencer with memory-ready stalls
// Rev 1.0
// ============================================================================
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal
);

    state_t     state;
    state_t     next_state;
    logic       pc_write_en;
    logic       mem_write_en;
    logic       ir_write_en;
    logic       reg_write_en;
    logic       illegal_en;
    logic [1:0] alu_op;
    logic       is_rtype;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state   = S_FETCH;
        pc_write_en  = 1'b0;
        mem_write_en = 1'b0;
        ir_write_en  = 1'b0;
        reg_write_en = 1'b0;
        illegal_en   = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_WD;
        ImmSrc       = IMM_I;
        alu_op       = ALUOP_ADD;
        is_rtype     = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                ir_write_en = mem_ready;
                pc_write_en = mem_ready;
                next_state  = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                // JAL needs its own target in ALUOut before the JAL state
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    default: begin
                        illegal_en = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = (op == OP_STORE) ? IMM_S : IMM_I;
                next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc    = RES_DATA;
                reg_write_en = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                mem_write_en = 1'b1;
                next_state   = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_A;
                alu_op     = ALUOP_FUNCT;
                is_rtype   = 1'b1;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_en = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = SRCA_A;
                alu_op      = ALUOP_SUB;
                pc_write_en = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
            end
            S_JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                pc_write_en = 1'b1;
                next_state  = S_ALUWB;
            end
            default: next_state = S_FETCH;
        endcase
    end

    alu_dec u_alu_dec (
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .is_rtype   (is_rtype),
        .alu_op     (alu_op),
        .ALUControl (ALUControl)
    );

    // State is already forced to FETCH by the async reset; FETCH's
    // mem_ready-driven enables still need masking while reset is held.
    assign PCWrite  = pc_write_en  & reset;
    assign IRWrite  = ir_write_en  & reset;
    assign MemWrite = mem_write_en & reset;
    assign RegWrite = reg_write_en & reset;
    assign illegal  = illegal_en   & reset;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// tb_mc_controller : self-checking bench for the multicycle controller
// Rev 1.0
// ============================================================================
module tb_mc_controller;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [3:0] alu;
        logic [1:0] imm;
        logic       regw;
        logic       ill;
    } outs_t;

    typedef struct {
        string      nm;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rst_drv = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [3:0] ALUControl;
    outs_t      act;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .illegal    (illegal)
    );

    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUControl, ImmSrc, RegWrite, illegal};

    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input logic rt);
        case (f3)
            3'd0:    return (f7 && rt) ? 4'b0001 : 4'b0000;
            3'd1:    return 4'b0110;
            3'd2:    return 4'b0101;
            3'd3:    return 4'b1001;
            3'd4:    return 4'b0100;
            3'd5:    return f7 ? 4'b1000 : 4'b0111;
            3'd6:    return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    endfunction

    function automatic bit is_wait(input string s);
        return (s == "FETCH") || (s == "MEMREAD") || (s == "MEMWRITE");
    endfunction

    // Expected control word for one named step of an instruction
    function automatic outs_t expect_out(input string s, input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7, input logic z, input logic mr);
        outs_t e;
        logic  rt;
        e  = '0;
        rt = (o == 7'b0110011);
        case (s)
            "FETCH":    begin e.sb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
            "DECODE":   begin e.sa = 2'b01; e.sb = 2'b01; e.imm = (o == 7'b1101111) ? 2'b11 : 2'b10;
                              e.ill = !is_legal(o); end
            "MEMADR":   begin e.sa = 2'b10; e.sb = 2'b01; e.imm = (o == 7'b0100011) ? 2'b01 : 2'b00; end
            "MEMREAD":  begin e.adr = 1'b1; end
            "MEMWRITE": begin e.adr = 1'b1; e.memw = 1'b1; end
            "MEMWB":    begin e.res = 2'b01; e.regw = 1'b1; end
            "EXEC":     begin e.sa = 2'b10; e.sb = rt ? 2'b00 : 2'b01; e.alu = alu_ref(f3, f7, rt); end
            "ALUWB":    begin e.regw = 1'b1; end
            "BRANCH":   begin e.sa = 2'b10; e.alu = 4'b0001;
                              e.pcw = ((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z); end
            "JAL":      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            default:    e = '0;
        endcase
        return e;
    endfunction

    function automatic outs_t in_reset(input outs_t e);
        outs_t g;
        g      = e;
        g.pcw  = 1'b0;
        g.irw  = 1'b0;
        g.memw = 1'b0;
        g.regw = 1'b0;
        g.ill  = 1'b0;
        return g;
    endfunction

    task automatic check(input string nm, input outs_t e);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h (op=%b f3=%b f7=%b z=%b mr=%b rst=%b)",
                     nm, act, e, op, funct3, funct7b5, Zero, mem_ready, reset);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic cyc(input string s, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic mr);
        outs_t e;
        @(negedge clk);
        reset = rst_drv; op = o; funct3 = f3; funct7b5 = f7; Zero = z; mem_ready = mr;
        #1;
        e = expect_out(s, o, f3, f7, z, mr);
        if (!reset) e = in_reset(e);
        check(s, e);
        @(posedge clk);
    endtask

    // Walks one instruction through its steps; junk IR fields during FETCH
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                             input int stall_pct, input string stall_at, input int stall_n,
                             output int cycles);
        string q[$];
        string s;
        logic  mr;
        int    stalled;
        int    run;
        stalled = 0;
        run     = 0;
        cycles  = 0;
        q.push_back("FETCH");
        q.push_back("DECODE");
        if (o == 7'b0000011)      begin q.push_back("MEMADR"); q.push_back("MEMREAD"); q.push_back("MEMWB"); end
        else if (o == 7'b0100011) begin q.push_back("MEMADR"); q.push_back("MEMWRITE"); end
        else if (o == 7'b0110011 || o == 7'b0010011) begin q.push_back("EXEC"); q.push_back("ALUWB"); end
        else if (o == 7'b1100011) q.push_back("BRANCH");
        else if (o == 7'b1101111) begin q.push_back("JAL"); q.push_back("ALUWB"); end
        while (q.size() > 0) begin
            s  = q[0];
            mr = 1'b1;
            if (s == stall_at && stalled < stall_n) begin
                mr = 1'b0;
                stalled++;
            end else if (stall_pct > 0 && !is_wait(s)) begin
                mr = 1'($urandom_range(1));
            end else if (stall_pct > 0 && run < 4 && $urandom_range(99) < stall_pct) begin
                mr = 1'b0;
                run++;
            end
            if (is_wait(s) && mr) run = 0;
            if (s == "FETCH")
                cyc(s, 7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), mr);
            else
                cyc(s, o, f3, f7, (s == "BRANCH") ? z : 1'($urandom), mr);
            cycles++;
            if (!is_wait(s) || mr) void'(q.pop_front());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[15];
        int         n;
        logic [6:0] ops[7];
        logic [6:0] o;
        int         k;

        tbl[0]  = '{"lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 5};
        tbl[1]  = '{"sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 4};
        tbl[2]  = '{"add",   7'b0110011, 3'b000, 1'b0, 1'b0, 4};
        tbl[3]  = '{"sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 4};
        tbl[4]  = '{"sra",   7'b0110011, 3'b101, 1'b1, 1'b0, 4};
        tbl[5]  = '{"sltu",  7'b0110011, 3'b011, 1'b0, 1'b0, 4};
        tbl[6]  = '{"addi7", 7'b0010011, 3'b000, 1'b1, 1'b0, 4};
        tbl[7]  = '{"srli",  7'b0010011, 3'b101, 1'b0, 1'b0, 4};
        tbl[8]  = '{"beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 3};
        tbl[9]  = '{"bne_z", 7'b1100011, 3'b001, 1'b0, 1'b1, 3};
        tbl[10] = '{"bne_n", 7'b1100011, 3'b001, 1'b0, 1'b0, 3};
        tbl[11] = '{"blt",   7'b1100011, 3'b100, 1'b0, 1'b1, 3};
        tbl[12] = '{"jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 4};
        tbl[13] = '{"ecall", 7'b1110011, 3'b000, 1'b0, 1'b0, 2};
        tbl[14] = '{"zero",  7'b0000000, 3'b000, 1'b0, 1'b0, 2};

        // Reset held for 3 cycles: FETCH selects, no enables
        rst_drv = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("FETCH", 7'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b1);
        rst_drv = 1'b1;

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, 0, "", 0, n);
            check_int({"cycles_", tbl[i].nm}, n, tbl[i].cyc);
        end

        // lw with two not-ready cycles in MEMREAD
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, "MEMREAD", 2, n);
        check_int("cycles_lw_stall", n, 7);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, "MEMWRITE", 3, n);
        check_int("cycles_sw_stall", n, 7);
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 0, "FETCH", 2, n);
        check_int("cycles_and_fstall", n, 6);

        // Reset asserted while stalled in MEMWRITE
        cyc("FETCH",    7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc("DECODE",   7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        cyc("MEMADR",   7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        cyc("MEMWRITE", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("memwrite_held", expect_out("MEMWRITE", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0));
        reset   = 1'b0;
        rst_drv = 1'b0;
        #1;
        check("reset_in_memwrite", in_reset(expect_out("FETCH", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0)));
        cyc("FETCH", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        rst_drv = 1'b1;
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, "", 0, n);
        check_int("cycles_after_reset", n, 4);

        // Random instruction stream with random memory stalls
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1110011};
        for (int i = 0; i < 300; i++) begin
            k = int'($urandom_range(7));
            o = (k == 7) ? 7'($urandom) : ops[k];
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), 30, "", 0, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
